// File: rtl/dvi_rx_link_ctrl.sv
// Link supervisor for the DVI receive path: sequences PLL lock, channel settle,
// frame alignment and frame-stability qualification, and requests decoder re-sync on loss.
module dvi_rx_link_ctrl #(
    parameter int SETTLE_CYC  = 1024,
    parameter int TIMEOUT_CYC = 2**22,
    parameter int GOOD_FRAMES = 3,
    parameter int RESYNC_LEN  = 16,
    parameter bit VS_POL      = 1'b1
) (
    input  logic        pclk,
    input  logic        rstbtn_n,
    input  logic        plllckd,
    input  logic        data_vld,
    input  logic        data_rdy,
    input  logic        psalgnerr,
    input  logic        vsync,
    input  logic        de,
    output logic        link_up,
    output logic        frame_start,
    output logic        resync_req,
    output logic [11:0] lines_per_frm,
    output logic [2:0]  state,
    output logic [7:0]  err_cnt
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int RS_W     = $clog2(RESYNC_LEN + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [RS_W-1:0]     RS_LAST     = RS_W'(RESYNC_LEN - 1);
    localparam logic [3:0]          GOOD_LOCK   = 4'(GOOD_FRAMES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_RDY   = 3'd1,
        WAIT_FRAME = 3'd2,
        QUALIFY    = 3'd3,
        LOCKED     = 3'd4,
        RESYNC     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [RS_W-1:0]     rs_q, rs_d;
    logic [11:0]         line_q, line_d;
    logic [11:0]         ref_q, ref_d;
    logic [11:0]         lpf_q, lpf_d;
    logic [3:0]          good_q, good_d;
    logic [7:0]          err_q, err_d;
    logic                vs_q, de_q;
    logic                link_up_q, frame_start_q, resync_req_q;

    logic        vs_edge, de_rise, link_ok, loss;
    logic [11:0] line_sat;

    assign vs_edge  = (vsync == VS_POL) && (vs_q != VS_POL);
    assign de_rise  = de && !de_q;
    assign link_ok  = data_vld && data_rdy;
    assign loss     = !link_ok || psalgnerr;
    // Running line count including a de rise in this very cycle; this is the frame count at vs_edge.
    assign line_sat = (&line_q) ? line_q : line_q + 12'(de_rise);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        rs_d     = rs_q;
        line_d   = line_q;
        ref_d    = ref_q;
        lpf_d    = lpf_q;
        good_d   = good_q;
        err_d    = err_q;

        if (!plllckd && state_q != RESYNC) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    settle_d = '0;
                    tmo_d    = '0;
                    state_d  = WAIT_RDY;
                end
                WAIT_RDY: begin
                    settle_d = link_ok ? settle_q + 1'b1 : '0;
                    tmo_d    = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST)
                        state_d = RESYNC;
                    else if (link_ok && settle_q == SETTLE_LAST)
                        state_d = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    tmo_d = tmo_q + 1'b1;
                    if (loss) begin
                        state_d = RESYNC;
                    end else if (vs_edge) begin
                        state_d = QUALIFY;
                        line_d  = '0;
                        good_d  = '0;
                        ref_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = RESYNC;
                    end
                end
                QUALIFY: begin
                    line_d = line_sat;
                    if (loss) begin
                        state_d = RESYNC;
                    end else if (vs_edge) begin
                        line_d = '0;
                        if (line_sat != '0 && line_sat == ref_q) begin
                            good_d = good_q + 1'b1;
                        end else begin
                            good_d = (line_sat != '0) ? 4'd1 : 4'd0;
                            ref_d  = line_sat;
                        end
                        if (good_d == GOOD_LOCK) begin
                            state_d = LOCKED;
                            lpf_d   = ref_d;
                        end
                    end
                end
                LOCKED: begin
                    line_d = line_sat;
                    if (loss) begin
                        state_d = RESYNC;
                    end else if (vs_edge) begin
                        line_d = '0;
                        if (line_sat != lpf_q)
                            state_d = RESYNC;
                    end
                end
                RESYNC: begin
                    rs_d = rs_q + 1'b1;
                    if (rs_q == RS_LAST)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q)
            tmo_d = '0;
        if (state_d == RESYNC && state_q != RESYNC) begin
            rs_d = '0;
            if (err_q != 8'hFF)
                err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge pclk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch, not the sensitivity list.
        if (!rstbtn_n) begin
            state_q       <= IDLE;
            settle_q      <= '0;
            tmo_q         <= '0;
            rs_q          <= '0;
            line_q        <= '0;
            ref_q         <= '0;
            lpf_q         <= '0;
            good_q        <= '0;
            err_q         <= '0;
            vs_q          <= !VS_POL;
            de_q          <= 1'b0;
            link_up_q     <= 1'b0;
            frame_start_q <= 1'b0;
            resync_req_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state_q       <= state_d;
            settle_q      <= settle_d;
            tmo_q         <= tmo_d;
            rs_q          <= rs_d;
            line_q        <= line_d;
            ref_q         <= ref_d;
            lpf_q         <= lpf_d;
            good_q        <= good_d;
            err_q         <= err_d;
            vs_q          <= vsync;
            de_q          <= de;
            link_up_q     <= (state_d == LOCKED);
            // The locking edge also starts the first delivered frame.
            frame_start_q <= vs_edge && (state_d == LOCKED);
            resync_req_q  <= (state_d == RESYNC);
        end
    end

    assign link_up       = link_up_q;
    assign frame_start   = frame_start_q;
    assign resync_req    = resync_req_q;
    assign lines_per_frm = lpf_q;
    assign state         = state_q;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_dvi_rx_link_ctrl.sv
// Bench for dvi_rx_link_ctrl: table of frame-sequence vectors plus hand sequences for
// timeouts, loss events, reset and err_cnt saturation; frame_start pulses are scoreboarded.
module tb_dvi_rx_link_ctrl;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 200;
    localparam int GOOD    = 3;
    localparam int RS_LEN  = 4;

    logic        pclk;
    logic        rstbtn_n;
    logic        plllckd;
    logic        data_vld;
    logic        data_rdy;
    logic        psalgnerr;
    logic        vsync;
    logic        de;
    logic        link_up;
    logic        frame_start;
    logic        resync_req;
    logic [11:0] lines_per_frm;
    logic [2:0]  state;
    logic [7:0]  err_cnt;

    dvi_rx_link_ctrl #(
        .SETTLE_CYC (SETTLE),
        .TIMEOUT_CYC(TIMEOUT),
        .GOOD_FRAMES(GOOD),
        .RESYNC_LEN (RS_LEN),
        .VS_POL     (1'b1)
    ) dut (
        .pclk         (pclk),
        .rstbtn_n     (rstbtn_n),
        .plllckd      (plllckd),
        .data_vld     (data_vld),
        .data_rdy     (data_rdy),
        .psalgnerr    (psalgnerr),
        .vsync        (vsync),
        .de           (de),
        .link_up      (link_up),
        .frame_start  (frame_start),
        .resync_req   (resync_req),
        .lines_per_frm(lines_per_frm),
        .state        (state),
        .err_cnt      (err_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        int    nfr;
        int    lines [6];
        int    exp_state;
        int    exp_lu;
        int    exp_lpf;
    } vec_t;

    vec_t vecs[$];
    int   sb[$];
    logic mon_en = 1'b0;
    int   mon_exp;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every frame_start must match a queued expectation carrying the locked line count.
    always @(negedge pclk) begin
        if (mon_en && frame_start) begin
            check("fs_link_up", int'(link_up), 1);
            if (sb.size() == 0) begin
                check("fs_unexpected", int'(frame_start), 0);
            end else begin
                mon_exp = sb.pop_front();
                check("fs_lines", int'(lines_per_frm), mon_exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic send_lines(input int n);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            cyc(3);
            de = 1'b0;
            cyc(2);
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        cyc(2);
    endtask

    task automatic send_frame(input int n);
        send_lines(n);
        vs_pulse();
    endtask

    task automatic add_vec(input string nm, input int n, input int l0, input int l1,
                           input int l2, input int l3, input int l4, input int l5,
                           input int st, input int lu, input int lpf);
        vec_t v;
        v.name = nm;
        v.nfr = n;
        v.lines[0] = l0; v.lines[1] = l1; v.lines[2] = l2;
        v.lines[3] = l3; v.lines[4] = l4; v.lines[5] = l5;
        v.exp_state = st;
        v.exp_lu = lu;
        v.exp_lpf = lpf;
        vecs.push_back(v);
    endtask

    // From IDLE (optionally via reset) to WAIT_FRAME with exact settle timing checked.
    task automatic reach_wait_frame(input bit do_reset);
        if (do_reset) begin
            rstbtn_n = 1'b0;
            cyc(1);
        end
        rstbtn_n  = 1'b1;
        plllckd   = 1'b1;
        data_vld  = 1'b1;
        data_rdy  = 1'b1;
        psalgnerr = 1'b0;
        vsync     = 1'b0;
        de        = 1'b0;
        cyc(1);
        check("wait_rdy_entry", int'(state), 1);
        cyc(SETTLE - 1);
        check("settle_not_yet", int'(state), 1);
        cyc(1);
        check("wait_frame_entry", int'(state), 2);
    endtask

    task automatic lock_at(input int n, input bit do_reset);
        reach_wait_frame(do_reset);
        vs_pulse();
        sb.push_back(n);
        repeat (GOOD) send_frame(n);
        check("lock_link_up", int'(link_up), 1);
        check("lock_lines", int'(lines_per_frm), n);
    endtask

    initial begin
        rstbtn_n  = 1'b0;
        plllckd   = 1'b0;
        data_vld  = 1'b0;
        data_rdy  = 1'b0;
        psalgnerr = 1'b0;
        vsync     = 1'b0;
        de        = 1'b0;

        add_vec("lock10",      3, 10, 10, 10,  0,  0,  0, 4, 1, 10);
        add_vec("seq10_11",    4, 10, 11, 11, 11,  0,  0, 4, 1, 11);
        add_vec("short_seq",   3, 10, 11, 11,  0,  0,  0, 3, 0, 0);
        add_vec("zero_mid",    5, 10, 10,  0, 10, 10,  0, 3, 0, 0);
        add_vec("zero_relock", 6, 10, 10,  0, 10, 10, 10, 4, 1, 10);
        add_vec("one_line",    3,  1,  1,  1,  0,  0,  0, 4, 1, 1);
        add_vec("all_zero",    4,  0,  0,  0,  0,  0,  0, 3, 0, 0);

        cyc(2);
        check("rst_state", int'(state), 0);
        check("rst_link_up", int'(link_up), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_resync_req", int'(resync_req), 0);
        check("rst_lines", int'(lines_per_frm), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        mon_en = 1'b1;

        foreach (vecs[k]) begin
            reach_wait_frame(1'b1);
            vs_pulse();
            check({vecs[k].name, "_qualify"}, int'(state), 3);
            if (vecs[k].exp_lu != 0)
                sb.push_back(vecs[k].exp_lpf);
            for (int i = 0; i < vecs[k].nfr; i++)
                send_frame(vecs[k].lines[i]);
            check({vecs[k].name, "_state"}, int'(state), vecs[k].exp_state);
            check({vecs[k].name, "_link_up"}, int'(link_up), vecs[k].exp_lu);
            check({vecs[k].name, "_lines"}, int'(lines_per_frm), vecs[k].exp_lpf);
        end

        // WAIT_RDY with vld toggling every 5 cycles never settles and times out.
        rstbtn_n = 1'b0;
        cyc(1);
        rstbtn_n = 1'b1;
        plllckd  = 1'b1;
        data_vld = 1'b1;
        data_rdy = 1'b1;
        cyc(1);
        check("tmo_wait_rdy_entry", int'(state), 1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            data_vld = ((i / 5) % 2 == 0);
            cyc(1);
        end
        check("tmo_still_wait", int'(state), 1);
        cyc(1);
        check("tmo_resync_state", int'(state), 5);
        check("tmo_err_cnt", int'(err_cnt), 1);
        for (int j = 1; j < RS_LEN; j++) begin
            check("resync_req_first", int'(resync_req), 1);
            cyc(1);
        end
        check("resync_req_last", int'(resync_req), 1);
        cyc(1);
        check("resync_req_drop", int'(resync_req), 0);
        check("resync_to_idle", int'(state), 0);

        // WAIT_FRAME timeout boundary.
        reach_wait_frame(1'b1);
        cyc(TIMEOUT - 1);
        check("tmo_wf_still", int'(state), 2);
        cyc(1);
        check("tmo_wf_resync", int'(state), 5);

        // Locked at 10: a good frame pulses, a 9-line frame forces RESYNC without pulse.
        lock_at(10, 1'b1);
        sb.push_back(10);
        send_frame(10);
        check("locked_keep", int'(state), 4);
        send_lines(9);
        vsync = 1'b1;
        cyc(1);
        check("mismatch_state", int'(state), 5);
        check("mismatch_link_up", int'(link_up), 0);
        check("mismatch_fs", int'(frame_start), 0);
        check("mismatch_err", int'(err_cnt), 1);
        cyc(1);
        vsync = 1'b0;
        cyc(RS_LEN + 2);

        // psalgnerr for one cycle, then relock and drop plllckd.
        lock_at(10, 1'b1);
        psalgnerr = 1'b1;
        cyc(1);
        psalgnerr = 1'b0;
        check("psal_resync", int'(state), 5);
        check("psal_link_up", int'(link_up), 0);
        cyc(RS_LEN);
        check("psal_idle", int'(state), 0);
        lock_at(11, 1'b0);
        plllckd = 1'b0;
        cyc(1);
        check("pll_drop_state", int'(state), 0);
        check("pll_drop_link_up", int'(link_up), 0);
        check("pll_drop_err", int'(err_cnt), 1);

        // Reset while LOCKED clears everything, err_cnt included.
        lock_at(7, 1'b0);
        rstbtn_n = 1'b0;
        cyc(1);
        check("lk_rst_state", int'(state), 0);
        check("lk_rst_link_up", int'(link_up), 0);
        check("lk_rst_fs", int'(frame_start), 0);
        check("lk_rst_resync", int'(resync_req), 0);
        check("lk_rst_lines", int'(lines_per_frm), 0);
        check("lk_rst_err", int'(err_cnt), 0);
        rstbtn_n = 1'b1;

        // Force 300 RESYNCs via psalgnerr held high in WAIT_FRAME.
        begin
            int   entries = 0;
            int   budget  = 0;
            logic prev    = 1'b0;
            plllckd   = 1'b1;
            data_vld  = 1'b1;
            data_rdy  = 1'b1;
            psalgnerr = 1'b1;
            while (entries < 300 && budget < 8000) begin
                cyc(1);
                budget++;
                if (resync_req && !prev)
                    entries++;
                prev = resync_req;
            end
            check("resync_entries", entries, 300);
            check("err_cnt_sat", int'(err_cnt), 255);
            psalgnerr = 1'b0;
        end

        cyc(2);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
